// File: rtl/taxi_axil_pkg.sv
// Shared AXI4-lite definitions: response codes and the default address-map helper.
package taxi_axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Upper bound on port*region count handled by the default-map helper.
   localparam int unsigned MAX_REGIONS = 64;
   localparam int unsigned MAP_W       = MAX_REGIONS * 32;

   // Base of region idx when regions are packed in order, each aligned to its own size.
   function automatic logic [63:0] default_base(input logic [MAP_W-1:0] widths,
                                                input int unsigned      idx);
      logic [63:0] base;
      logic [63:0] size;
      logic [31:0] w;
      base = '0;
      size = '0;
      w    = '0;
      default_base = '0;
      for (int unsigned i = 0; i < MAX_REGIONS; i++) begin
         if (i <= idx) begin
            w = widths[i*32 +: 32];
            if (w != 32'd0) begin
               size = 64'd1 << w;
               base = (base + size - 64'd1) & ~(size - 64'd1);
               if (i == idx) default_base = base;
               base = base + size;
            end
         end
      end
   endfunction

endpackage

// File: rtl/taxi_axil_if.sv
// AXI4-lite read channels (AR/R) with slave- and master-side views.
interface taxi_axil_if #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ARUSER_W = 1,
   parameter int unsigned RUSER_W  = 1
) ();
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic [ARUSER_W-1:0] aruser;
   logic                arvalid;
   logic                arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic [RUSER_W-1:0]  ruser;
   logic                rvalid;
   logic                rready;

   modport rd_slv (input araddr, arprot, aruser, arvalid, rready,
                   output arready, rdata, rresp, ruser, rvalid);
   modport rd_mst (output araddr, arprot, aruser, arvalid, rready,
                   input arready, rdata, rresp, ruser, rvalid);
endinterface

// File: rtl/taxi_axil_addr_decode.sv
// Combinational address/protection decode to {hit, port index}; lowest port/region wins.
module taxi_axil_addr_decode
   import taxi_axil_pkg::*;
#(
   parameter int unsigned M_COUNT   = 4,
   parameter int unsigned M_REGIONS = 1,
   parameter int unsigned ADDR_W    = 32,
   parameter logic [M_COUNT*M_REGIONS*ADDR_W-1:0] M_BASE_ADDR = '0,
   parameter logic [M_COUNT*M_REGIONS*32-1:0]     M_ADDR_W    = {M_COUNT{{M_REGIONS{32'd24}}}},
   parameter logic [M_COUNT-1:0]                  M_SECURE    = '0,
   localparam int unsigned SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        prot,
   output logic              hit_c,
   output logic [SEL_W-1:0]  sel_c
);

   localparam int unsigned N           = M_COUNT * M_REGIONS;
   localparam bit          USE_DEFAULT = (M_BASE_ADDR == '0);

   logic [N-1:0] region_hit;
   logic         unused_prot;

   assign unused_prot = ^{prot[2], prot[0]};

   if (N > MAX_REGIONS) begin : g_err_count
      $fatal(1, "taxi_axil_addr_decode: too many regions");
   end

   // Per-region compare of the address bits above the region width.
   for (genvar k = 0; k < N; k++) begin : g_region
      localparam int unsigned W = M_ADDR_W[k*32 +: 32];
      localparam logic [ADDR_W-1:0] BASE = USE_DEFAULT
         ? ADDR_W'(default_base(MAP_W'(M_ADDR_W), k))
         : M_BASE_ADDR[k*ADDR_W +: ADDR_W];

      if (W > ADDR_W) begin : g_err_width
         $fatal(1, "taxi_axil_addr_decode: region width exceeds ADDR_W");
      end else if (W == 0) begin : g_off
         assign region_hit[k] = 1'b0;
      end else if (W == ADDR_W) begin : g_all
         if (BASE != '0) begin : g_err_align
            $fatal(1, "taxi_axil_addr_decode: base not aligned");
         end
         assign region_hit[k] = 1'b1;
      end else begin : g_cmp
         if (BASE[W-1:0] != '0) begin : g_err_align
            $fatal(1, "taxi_axil_addr_decode: base not aligned");
         end
         assign region_hit[k] = (addr[ADDR_W-1:W] == BASE[ADDR_W-1:W]);
      end
   end

   // Priority select; a secure port refusing a non-secure access counts as a miss.
   always_comb begin
      hit_c = 1'b0;
      sel_c = '0;
      for (int unsigned i = 0; i < M_COUNT; i++) begin
         for (int unsigned r = 0; r < M_REGIONS; r++) begin
            if (!hit_c && region_hit[i*M_REGIONS + r] && !(M_SECURE[i] && prot[1])) begin
               hit_c = 1'b1;
               sel_c = SEL_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/taxi_axil_demux_rd.sv
// AXI4-lite read demultiplexer: one slave port to M_COUNT master ports, one read in flight.
module taxi_axil_demux_rd
   import taxi_axil_pkg::*;
#(
   parameter int unsigned M_COUNT   = 4,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned M_REGIONS = 1,
   parameter logic [M_COUNT*M_REGIONS*ADDR_W-1:0] M_BASE_ADDR = '0,
   parameter logic [M_COUNT*M_REGIONS*32-1:0]     M_ADDR_W    = {M_COUNT{{M_REGIONS{32'd24}}}},
   parameter logic [M_COUNT-1:0]                  M_SECURE    = {M_COUNT{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   taxi_axil_if.rd_slv  s_axil_rd,
   taxi_axil_if.rd_mst  m_axil_rd [M_COUNT]
);

   localparam int unsigned DATA_W   = s_axil_rd.DATA_W;
   localparam int unsigned ARUSER_W = s_axil_rd.ARUSER_W;
   localparam int unsigned RUSER_W  = s_axil_rd.RUSER_W;
   localparam int unsigned SEL_W    = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

   if (ADDR_W != s_axil_rd.ADDR_W) begin : g_err_addr_w
      $fatal(1, "taxi_axil_demux_rd: ADDR_W does not match interface");
   end

   typedef enum logic [1:0] {IDLE, FWD_AR, WAIT_R, RESP} state_t;

   state_t              state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2:0]          prot_q, prot_d;
   logic [ARUSER_W-1:0] aruser_q, aruser_d;
   logic                arready_q, arready_d;
   logic                rvalid_q, rvalid_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [1:0]          rresp_q, rresp_d;
   logic [RUSER_W-1:0]  ruser_q, ruser_d;
   logic [M_COUNT-1:0]  m_arvalid_q, m_arvalid_d;
   logic [M_COUNT-1:0]  m_rready_q, m_rready_d;

   logic [M_COUNT-1:0]  m_arready;
   logic [M_COUNT-1:0]  m_rvalid;
   logic [DATA_W-1:0]   m_rdata [M_COUNT];
   logic [1:0]          m_rresp [M_COUNT];
   logic [RUSER_W-1:0]  m_ruser [M_COUNT];

   logic                dec_hit;
   logic [SEL_W-1:0]    dec_sel;

   taxi_axil_addr_decode #(
      .M_COUNT     (M_COUNT),
      .M_REGIONS   (M_REGIONS),
      .ADDR_W      (ADDR_W),
      .M_BASE_ADDR (M_BASE_ADDR),
      .M_ADDR_W    (M_ADDR_W),
      .M_SECURE    (M_SECURE)
   ) u_decode (
      .addr  (s_axil_rd.araddr),
      .prot  (s_axil_rd.arprot),
      .hit_c (dec_hit),
      .sel_c (dec_sel)
   );

   assign s_axil_rd.arready = arready_q;
   assign s_axil_rd.rvalid  = rvalid_q;
   assign s_axil_rd.rdata   = rdata_q;
   assign s_axil_rd.rresp   = rresp_q;
   assign s_axil_rd.ruser   = ruser_q;

   // Fan the latched request out to every port; only the selected one sees valid/ready.
   for (genvar i = 0; i < M_COUNT; i++) begin : g_port
      assign m_axil_rd[i].araddr  = addr_q;
      assign m_axil_rd[i].arprot  = prot_q;
      assign m_axil_rd[i].aruser  = aruser_q;
      assign m_axil_rd[i].arvalid = m_arvalid_q[i];
      assign m_axil_rd[i].rready  = m_rready_q[i];
      assign m_arready[i] = m_axil_rd[i].arready;
      assign m_rvalid[i]  = m_axil_rd[i].rvalid;
      assign m_rdata[i]   = m_axil_rd[i].rdata;
      assign m_rresp[i]   = m_axil_rd[i].rresp;
      assign m_ruser[i]   = m_axil_rd[i].ruser;
   end

   // Next-state and next-output computation for the single-transaction sequencer.
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      addr_d      = addr_q;
      prot_d      = prot_q;
      aruser_d    = aruser_q;
      arready_d   = arready_q;
      rvalid_d    = rvalid_q;
      rdata_d     = rdata_q;
      rresp_d     = rresp_q;
      ruser_d     = ruser_q;
      m_arvalid_d = m_arvalid_q;
      m_rready_d  = m_rready_q;

      unique case (state_q)
         IDLE: begin
            arready_d = 1'b1;
            if (arready_q && s_axil_rd.arvalid) begin
               arready_d = 1'b0;
               addr_d    = s_axil_rd.araddr;
               prot_d    = s_axil_rd.arprot;
               aruser_d  = s_axil_rd.aruser;
               sel_d     = dec_sel;
               if (dec_hit) begin
                  m_arvalid_d = M_COUNT'(1) << dec_sel;
                  state_d     = FWD_AR;
               end else begin
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  rresp_d  = RESP_DECERR;
                  ruser_d  = '0;
                  state_d  = RESP;
               end
            end
         end
         FWD_AR: begin
            if (m_arready[sel_q]) begin
               m_rready_d  = m_arvalid_q;
               m_arvalid_d = '0;
               state_d     = WAIT_R;
            end
         end
         WAIT_R: begin
            if (m_rvalid[sel_q] && m_rready_q[sel_q]) begin
               rdata_d    = m_rdata[sel_q];
               rresp_d    = m_rresp[sel_q];
               ruser_d    = m_ruser[sel_q];
               m_rready_d = '0;
               rvalid_d   = 1'b1;
               state_d    = RESP;
            end
         end
         RESP: begin
            if (rvalid_q && s_axil_rd.rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= '0;
         addr_q      <= '0;
         prot_q      <= '0;
         aruser_q    <= '0;
         arready_q   <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= '0;
         rresp_q     <= '0;
         ruser_q     <= '0;
         m_arvalid_q <= '0;
         m_rready_q  <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         addr_q      <= addr_d;
         prot_q      <= prot_d;
         aruser_q    <= aruser_d;
         arready_q   <= arready_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         rresp_q     <= rresp_d;
         ruser_q     <= ruser_d;
         m_arvalid_q <= m_arvalid_d;
         m_rready_q  <= m_rready_d;
      end
   end

endmodule
